// File: rtl/conv_unit.sv
// Multi-cycle WebAssembly conversion unit: wrap, extend, reinterpret and float->int truncation.
// Optional `define CONV_TRUNC_SAT_EN adds the 0xFC 0x00-0x07 saturating truncations.
module conv_unit #(
  parameter int USE_64B    = 1,
  parameter int SHIFT_STEP = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [8:0]  op,
  input  logic [63:0] in_data,
  input  logic [1:0]  in_type,
  output logic        busy,
  output logic        done,
  output logic [63:0] out_data,
  output logic [1:0]  out_type,
  output logic [3:0]  trap
);
  // Type and trap encodings shared with the cpu; bit 0 of a type marks a 64-bit type.
  localparam logic [1:0] T_I32 = 2'd0, T_I64 = 2'd1, T_F32 = 2'd2, T_F64 = 2'd3;
  localparam logic [3:0] TRAP_NONE         = 4'd0;
  localparam logic [3:0] TRAP_UNKNOWN_OP   = 4'd1;
  localparam logic [3:0] TRAP_INVALID_TYPE = 4'd2;
  localparam logic [3:0] TRAP_INT_OVERFLOW = 4'd3;
  localparam logic [3:0] TRAP_INVALID_CONV = 4'd4;
  localparam logic [3:0] TRAP_NO_64B       = 4'd5;
  localparam logic [6:0] STEP = 7'(SHIFT_STEP);

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_UNPACK, S_SHIFT, S_CHECK, S_FINISH
  } state_t;

  state_t      state_q;
  logic [8:0]  op_q;
  logic [63:0] data_q;
  logic [1:0]  type_q;
  logic [63:0] mag_q, res_q;
  logic [6:0]  cnt_q;
  logic        left_q, sign_q, nan_q, ovf_q;
  logic [1:0]  rtype_q;
  logic [3:0]  trp_q;
  logic        busy_q, done_q;
  logic [63:0] out_data_q;
  logic [1:0]  out_type_q;
  logic [3:0]  trap_q;

  // Op decode, evaluated on the latched op for the whole operation
  logic        dc_known, dc_trunc, dc_sat, dc_uns;
  logic [1:0]  dc_src, dc_dst;
  logic [2:0]  tr_idx;
  logic [63:0] dc_res;

  always_comb begin
    dc_known = 1'b1;
    dc_trunc = 1'b0;
    dc_sat   = 1'b0;
    dc_uns   = 1'b0;
    dc_src   = T_I32;
    dc_dst   = T_I32;
    tr_idx   = 3'd0;
    dc_res   = '0;
    case (op_q)
      9'h0A7: begin dc_src = T_I64; dc_dst = T_I32; dc_res = {32'h0, data_q[31:0]}; end
      9'h0AC: begin dc_src = T_I32; dc_dst = T_I64; dc_res = {{32{data_q[31]}}, data_q[31:0]}; end
      9'h0AD: begin dc_src = T_I32; dc_dst = T_I64; dc_res = {32'h0, data_q[31:0]}; end
      9'h0BC: begin dc_src = T_F32; dc_dst = T_I32; dc_res = {32'h0, data_q[31:0]}; end
      9'h0BD: begin dc_src = T_F64; dc_dst = T_I64; dc_res = data_q; end
      9'h0BE: begin dc_src = T_I32; dc_dst = T_F32; dc_res = {32'h0, data_q[31:0]}; end
      9'h0BF: begin dc_src = T_I64; dc_dst = T_F64; dc_res = data_q; end
      // tr_idx = {dst64, src_f64, unsigned}
      9'h0A8, 9'h0A9, 9'h0AA, 9'h0AB: begin
        dc_trunc = 1'b1;
        tr_idx   = {1'b0, op_q[1:0]};
      end
      9'h0AE, 9'h0AF, 9'h0B0, 9'h0B1: begin
        dc_trunc = 1'b1;
        tr_idx   = {1'b1, op_q[1:0] + 2'd2};
      end
`ifdef CONV_TRUNC_SAT_EN
      9'h100, 9'h101, 9'h102, 9'h103, 9'h104, 9'h105, 9'h106, 9'h107: begin
        dc_trunc = 1'b1;
        dc_sat   = 1'b1;
        tr_idx   = op_q[2:0];
      end
`endif
      default: dc_known = 1'b0;
    endcase
    if (dc_trunc) begin
      dc_src = tr_idx[1] ? T_F64 : T_F32;
      dc_dst = tr_idx[2] ? T_I64 : T_I32;
      dc_uns = tr_idx[0];
    end
  end

  logic dc_uses64;
  assign dc_uses64 = dc_src[0] | dc_dst[0];

  // Float field split; man carries the hidden bit, sh aligns its LSB to the binary point
  logic               f64_src, exp_max, frac_nz;
  logic [52:0]        man;
  logic signed [12:0] e_unb, sh;
  logic [6:0]         sh_abs;

  assign f64_src = dc_src[0];

  always_comb begin
    if (f64_src) begin
      exp_max = &data_q[62:52];
      frac_nz = |data_q[51:0];
      man     = {1'b1, data_q[51:0]};
      e_unb   = $signed({2'b0, data_q[62:52]}) - 13'sd1023;
      sh      = e_unb - 13'sd52;
    end else begin
      exp_max = &data_q[30:23];
      frac_nz = |data_q[22:0];
      man     = {29'h0, 1'b1, data_q[22:0]};
      e_unb   = $signed({5'b0, data_q[30:23]}) - 13'sd127;
      sh      = e_unb - 13'sd23;
    end
    sh_abs = sh[12] ? 7'(-sh) : 7'(sh);
  end

  logic [6:0] step;
  assign step = (cnt_q > STEP) ? STEP : cnt_q;

  // Range check on the aligned integer magnitude
  logic [63:0] max_pos, neg_lim, mag_neg, chk_res, sat_res;
  logic        chk_ovf;

  always_comb begin
    if (dc_dst[0]) max_pos = dc_uns ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h7FFF_FFFF_FFFF_FFFF;
    else           max_pos = dc_uns ? 64'h0000_0000_FFFF_FFFF : 64'h0000_0000_7FFF_FFFF;
    neg_lim = dc_uns ? 64'd0 : max_pos + 64'd1;
    chk_ovf = ovf_q | (sign_q ? (mag_q > neg_lim) : (mag_q > max_pos));
    mag_neg = sign_q ? (~mag_q + 64'd1) : mag_q;
    chk_res = dc_dst[0] ? mag_neg : {32'h0, mag_neg[31:0]};
    if (!sign_q)    sat_res = max_pos;
    else if (dc_uns) sat_res = 64'd0;
    else            sat_res = dc_dst[0] ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      data_q     <= '0;
      type_q     <= T_I32;
      mag_q      <= '0;
      res_q      <= '0;
      cnt_q      <= '0;
      left_q     <= 1'b0;
      sign_q     <= 1'b0;
      nan_q      <= 1'b0;
      ovf_q      <= 1'b0;
      rtype_q    <= T_I32;
      trp_q      <= TRAP_NONE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      out_data_q <= '0;
      out_type_q <= T_I32;
      trap_q     <= TRAP_NONE;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          op_q    <= op;
          data_q  <= in_data;
          type_q  <= in_type;
          busy_q  <= 1'b1;
          state_q <= S_DECODE;
        end
        S_DECODE: begin
          res_q   <= '0;
          mag_q   <= '0;
          nan_q   <= 1'b0;
          ovf_q   <= 1'b0;
          sign_q  <= f64_src ? data_q[63] : data_q[31];
          rtype_q <= dc_known ? dc_dst : T_I32;
          trp_q   <= TRAP_NONE;
          state_q <= S_FINISH;
          if (!dc_known)                    trp_q <= TRAP_UNKNOWN_OP;
          else if (type_q != dc_src)        trp_q <= TRAP_INVALID_TYPE;
          else if (USE_64B == 0 && dc_uses64) trp_q <= TRAP_NO_64B;
          else if (!dc_trunc)               res_q <= dc_res;
          else                              state_q <= S_UNPACK;
        end
        S_UNPACK: begin
          state_q <= S_CHECK;
          // Inf and anything >= 2^64 overflow every target, so they skip the shifter
          if (exp_max) begin
            nan_q <= frac_nz;
            ovf_q <= ~frac_nz;
          end else if (e_unb >= 13'sd64) begin
            ovf_q <= 1'b1;
          end else if (!e_unb[12]) begin
            mag_q <= {11'h0, man};
            if (sh != 13'sd0) begin
              left_q  <= ~sh[12];
              cnt_q   <= sh_abs;
              state_q <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          mag_q <= left_q ? (mag_q << step) : (mag_q >> step);
          cnt_q <= cnt_q - step;
          if (cnt_q == step) state_q <= S_CHECK;
        end
        S_CHECK: begin
          state_q <= S_FINISH;
          res_q   <= '0;
          trp_q   <= TRAP_NONE;
          if (nan_q) begin
            if (!dc_sat) trp_q <= TRAP_INVALID_CONV;
          end else if (chk_ovf) begin
            if (dc_sat) res_q <= sat_res;
            else        trp_q <= TRAP_INT_OVERFLOW;
          end else begin
            res_q <= chk_res;
          end
        end
        S_FINISH: begin
          out_data_q <= res_q;
          out_type_q <= rtype_q;
          trap_q     <= trp_q;
          done_q     <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign out_data = out_data_q;
  assign out_type = out_type_q;
  assign trap     = trap_q;

endmodule

// File: tb/tb_conv_unit.sv
// Bench for conv_unit: two instances (64-bit enabled, 64-bit disabled) against a real-arithmetic model.
module tb_conv_unit;
  localparam logic [1:0] I32 = 2'd0, I64 = 2'd1, F32 = 2'd2, F64 = 2'd3;
  localparam logic [3:0] TR_NONE = 4'd0, TR_UNK = 4'd1, TR_TYPE = 4'd2,
                         TR_OVF = 4'd3, TR_INV = 4'd4, TR_NO64 = 4'd5;
  localparam int  STEP_A = 8, STEP_B = 4;
  localparam real P31 = 2147483648.0, P32 = 4294967296.0;
  localparam real P63 = 9223372036854775808.0, P64 = 18446744073709551616.0;

  logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [8:0]  op = '0;
  logic [63:0] in_data = '0;
  logic [1:0]  in_type = '0;
  logic        busy_a, done_a, busy_b, done_b;
  logic [63:0] out_data_a, out_data_b;
  logic [1:0]  out_type_a, out_type_b;
  logic [3:0]  trap_a, trap_b;

  conv_unit #(.USE_64B(1), .SHIFT_STEP(STEP_A)) dut_a (
    .clk(clk), .reset(reset), .start(start), .op(op), .in_data(in_data), .in_type(in_type),
    .busy(busy_a), .done(done_a), .out_data(out_data_a), .out_type(out_type_a), .trap(trap_a));
  conv_unit #(.USE_64B(0), .SHIFT_STEP(STEP_B)) dut_b (
    .clk(clk), .reset(reset), .start(start), .op(op), .in_data(in_data), .in_type(in_type),
    .busy(busy_b), .done(done_b), .out_data(out_data_b), .out_type(out_type_b), .trap(trap_b));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic real f2r(input logic [63:0] d, input bit is64);
    logic [63:0] b;
    if (is64) return $bitstoreal(d);
    if (d[30:23] == 8'h00) return 0.0;
    if (d[30:23] == 8'hFF) b = {d[31], 11'h7FF, d[22:0], 29'h0};
    else                   b = {d[31], 11'(d[30:23]) + 11'd896, d[22:0], 29'h0};
    return $bitstoreal(b);
  endfunction

  // Two's-complement bits of trunc(r) for r inside (-2^63-1, 2^64)
  function automatic logic [63:0] trunc64(input real r);
    longint t;
    if (r >= P63) return 64'(longint'(r - P63)) + 64'h8000_0000_0000_0000;
    t = longint'(r);
    if (r >= 0.0 && real'(t) > r) t = t - 1;
    if (r < 0.0 && real'(t) < r)  t = t + 1;
    return 64'(t);
  endfunction

  task automatic model(input logic [8:0] o, input logic [63:0] d, input logic [1:0] ty,
                       input bit use64, input int stp,
                       output logic [63:0] rd, output logic [1:0] rt,
                       output logic [3:0] rx, output int lat);
    bit known = 1, trn = 0, sat = 0, uns = 0, dst64, src64, nan;
    logic [1:0] src = I32, dst = I32;
    int k = 0, e, mb, sh, n;
    real r, hi, lo_off;
    rd = '0; rt = I32; rx = TR_NONE; lat = 2;
    if (o >= 9'h0A8 && o <= 9'h0AB) begin trn = 1; k = int'(o) - 'hA8; end
    else if (o >= 9'h0AE && o <= 9'h0B1) begin trn = 1; k = int'(o) - 'hAE + 4; end
`ifdef CONV_TRUNC_SAT_EN
    else if (o >= 9'h100 && o <= 9'h107) begin trn = 1; sat = 1; k = int'(o) - 'h100; end
`endif
    else case (o)
      9'h0A7: begin src = I64; dst = I32; rd = {32'h0, d[31:0]}; end
      9'h0AC: begin src = I32; dst = I64; rd = 64'(longint'(int'(d[31:0]))); end
      9'h0AD: begin src = I32; dst = I64; rd = {32'h0, d[31:0]}; end
      9'h0BC: begin src = F32; dst = I32; rd = {32'h0, d[31:0]}; end
      9'h0BD: begin src = F64; dst = I64; rd = d; end
      9'h0BE: begin src = I32; dst = F32; rd = {32'h0, d[31:0]}; end
      9'h0BF: begin src = I64; dst = F64; rd = d; end
      default: known = 0;
    endcase
    if (trn) begin
      uns = (k % 2) == 1;
      src = ((k / 2) % 2 == 1) ? F64 : F32;
      dst = (k >= 4) ? I64 : I32;
    end
    if (!known) begin rd = '0; rx = TR_UNK; return; end
    rt = dst;
    if (ty != src) begin rd = '0; rx = TR_TYPE; return; end
    if (!use64 && (src inside {I64, F64} || dst inside {I64, F64})) begin
      rd = '0; rx = TR_NO64; return;
    end
    if (!trn) return;
    src64 = (src == F64);
    dst64 = (dst == I64);
    r   = f2r(d, src64);
    nan = src64 ? (&d[62:52] && |d[51:0]) : (&d[30:23] && |d[22:0]);
    e   = src64 ? int'(d[62:52]) - 1023 : int'(d[30:23]) - 127;
    mb  = src64 ? 52 : 23;
    if (e >= 0 && e < 64) begin
      sh  = (e > mb) ? e - mb : mb - e;
      lat = 4 + (sh + stp - 1) / stp;
    end else lat = 4;
    n      = dst64 ? 64 : 32;
    hi     = uns ? (dst64 ? P64 : P32) : (dst64 ? P63 : P31);
    lo_off = uns ? 0.0 : (dst64 ? P63 : P31);
    if (nan) begin
      rd = '0; rx = sat ? TR_NONE : TR_INV;
    end else if (r >= hi || r + lo_off <= -1.0) begin
      if (!sat)        begin rd = '0; rx = TR_OVF; end
      else if (r < 0.0) rd = uns ? 64'd0 : (dst64 ? 64'h8000_0000_0000_0000 : 64'h8000_0000);
      else             rd = uns ? (dst64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF)
                                : (dst64 ? 64'h7FFF_FFFF_FFFF_FFFF : 64'h7FFF_FFFF);
    end else begin
      rd = trunc64(r);
      if (n == 32) rd = {32'h0, rd[31:0]};
    end
  endtask

  logic [63:0] cap_d_a, cap_d_b;
  logic [1:0]  cap_t_a, cap_t_b;
  logic [3:0]  cap_x_a, cap_x_b;
  int          cap_l_a, cap_l_b;

  task automatic run_op(input logic [8:0] o, input logic [63:0] d, input logic [1:0] ty,
                        input bit poke);
    logic [63:0] ed_a, ed_b;
    logic [1:0]  et_a, et_b;
    logic [3:0]  ex_a, ex_b;
    int          el_a, el_b;
    model(o, d, ty, 1'b1, STEP_A, ed_a, et_a, ex_a, el_a);
    model(o, d, ty, 1'b0, STEP_B, ed_b, et_b, ex_b, el_b);
    cap_l_a = -1; cap_l_b = -1;
    @(negedge clk);
    op = o; in_data = d; in_type = ty; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    op = 9'($urandom); in_data = {$urandom, $urandom}; in_type = 2'($urandom);
    chk("busy_a", 64'(busy_a), 64'd1);
    chk("busy_b", 64'(busy_b), 64'd1);
    for (int c = 1; c <= 200 && (cap_l_a < 0 || cap_l_b < 0); c++) begin
      if (poke && c == 1) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (done_a && cap_l_a < 0) begin
        cap_l_a = c; cap_d_a = out_data_a; cap_t_a = out_type_a; cap_x_a = trap_a;
      end
      if (done_b && cap_l_b < 0) begin
        cap_l_b = c; cap_d_b = out_data_b; cap_t_b = out_type_b; cap_x_b = trap_b;
      end
    end
    chk($sformatf("lat_a op=%h", o), 64'(cap_l_a), 64'(el_a));
    chk($sformatf("lat_b op=%h", o), 64'(cap_l_b), 64'(el_b));
    if (cap_l_a >= 0) begin
      chk($sformatf("data_a op=%h in=%h", o, d), cap_d_a, ed_a);
      chk($sformatf("type_a op=%h", o), 64'(cap_t_a), 64'(et_a));
      chk($sformatf("trap_a op=%h in=%h", o, d), 64'(cap_x_a), 64'(ex_a));
    end
    if (cap_l_b >= 0) begin
      chk($sformatf("data_b op=%h in=%h", o, d), cap_d_b, ed_b);
      chk($sformatf("type_b op=%h", o), 64'(cap_t_b), 64'(et_b));
      chk($sformatf("trap_b op=%h in=%h", o, d), 64'(cap_x_b), 64'(ex_b));
    end
    @(posedge clk); #1;
    chk("done_pulse", 64'({done_a, done_b}), 64'd0);
    chk("idle_busy", 64'({busy_a, busy_b}), 64'd0);
    chk("hold_a", out_data_a, ed_a);
  endtask

  logic [31:0] bnd32 [8] = '{32'h4F000000, 32'hCF000000, 32'hBF800000, 32'h4F800000,
                             32'h5F000000, 32'hDF000000, 32'h5F800000, 32'h3F800000};
  logic [63:0] bnd64 [8] = '{64'h41E0000000000000, 64'hC1E0000000000000,
                             64'hC1E0000000200000, 64'hC1E0000000100000,
                             64'h43E0000000000000, 64'hC3E0000000000000,
                             64'h43F0000000000000, 64'hBFF0000000000000};
  logic [8:0]  ops [31] = '{9'h0A7, 9'h0A8, 9'h0A9, 9'h0AA, 9'h0AB, 9'h0AC, 9'h0AD,
                            9'h0AE, 9'h0AF, 9'h0B0, 9'h0B1, 9'h0BC, 9'h0BD, 9'h0BE, 9'h0BF,
                            9'h100, 9'h101, 9'h102, 9'h103, 9'h104, 9'h105, 9'h106, 9'h107,
                            9'h0A8, 9'h0A9, 9'h0AE, 9'h0B1, 9'h0A6, 9'h0B2, 9'h108, 9'h0C0};

  function automatic logic [63:0] rnd_float(input bit is64);
    logic [63:0] r;
    int sel, e;
    r   = {$urandom, $urandom};
    sel = $urandom_range(0, 11);
    if (sel == 0) begin
      if (is64) r[62:52] = '1; else r[30:23] = '1;
    end else if (sel == 1) begin
      if (is64) begin r[62:52] = '1; r[51:0] = '0; end
      else begin r[30:23] = '1; r[22:0] = '0; end
    end else if (sel == 2) begin
      if (is64) r[62:52] = '0; else r[30:23] = '0;
    end else if (sel <= 4) begin
      if (is64) r = bnd64[$urandom_range(0, 7)];
      else r[31:0] = bnd32[$urandom_range(0, 7)];
    end else begin
      e = $urandom_range(0, 80) - 8;
      if (is64) r[62:52] = 11'(e + 1023); else r[30:23] = 8'(e + 127);
    end
    return r;
  endfunction

  function automatic logic [1:0] src_of(input logic [8:0] o);
    case (o)
      9'h0A7, 9'h0BF: return I64;
      9'h0AC, 9'h0AD, 9'h0BE: return I32;
      9'h0BC, 9'h0A8, 9'h0A9, 9'h0AE, 9'h0AF,
      9'h100, 9'h101, 9'h104, 9'h105: return F32;
      9'h0BD, 9'h0AA, 9'h0AB, 9'h0B0, 9'h0B1,
      9'h102, 9'h103, 9'h106, 9'h107: return F64;
      default: return 2'($urandom);
    endcase
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0]  o;
    logic [1:0]  ty;
    logic [63:0] d;
    bit          seen;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'({busy_a, busy_b}), 64'd0);
    chk("rst_done", 64'({done_a, done_b}), 64'd0);
    chk("rst_data_a", out_data_a, 64'd0);
    chk("rst_type", 64'({out_type_a, out_type_b}), 64'({I32, I32}));
    chk("rst_trap", 64'({trap_a, trap_b}), 64'({TR_NONE, TR_NONE}));
    @(negedge clk) reset = 1'b0;

    run_op(9'h0BD, 64'hC000000000000000, F64, 1'b0);
    chk("spec_bd_data", cap_d_a, 64'hC000000000000000);
    chk("spec_bd_type", 64'(cap_t_a), 64'(I64));
    chk("spec_bd_lat", 64'(cap_l_a), 64'd2);
    chk("spec_bd_no64", 64'(cap_x_b), 64'(TR_NO64));
    chk("spec_bd_no64_lat", 64'(cap_l_b), 64'd2);
    run_op(9'h0AC, 64'h0000000080000000, I32, 1'b1);
    chk("spec_ac", cap_d_a, 64'hFFFFFFFF80000000);
    run_op(9'h0AD, 64'h0000000080000000, I32, 1'b1);
    chk("spec_ad", cap_d_a, 64'h0000000080000000);
    run_op(9'h0A9, 64'h00000000BF000000, F32, 1'b0);
    chk("spec_a9_half", cap_d_a, 64'd0);
    chk("spec_a9_trap", 64'(cap_x_a), 64'(TR_NONE));
    run_op(9'h0A8, 64'h000000007FC00000, F32, 1'b1);
    chk("spec_nan", 64'(cap_x_a), 64'(TR_INV));
    run_op(9'h0A8, 64'h000000004F000000, F32, 1'b0);
    chk("spec_ovf", 64'(cap_x_a), 64'(TR_OVF));
`ifdef CONV_TRUNC_SAT_EN
    run_op(9'h100, 64'h000000004F000000, F32, 1'b0);
    chk("spec_sat_max", cap_d_a, 64'h000000007FFFFFFF);
    run_op(9'h101, 64'h00000000BF800000, F32, 1'b0);
    chk("spec_sat_neg", cap_d_a, 64'd0);
`endif
    run_op(9'h0A8, 64'h00000000C2F6E979, F32, 1'b1);
    chk("spec_a8_data", cap_d_a, 64'h00000000FFFFFF85);
    chk("spec_a8_lat", 64'(cap_l_a), 64'd7);

    // Abort an operation while both instances are still shifting
    @(negedge clk);
    op = 9'h0A8; in_data = 64'h3FC00000; in_type = F32; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_busy", 64'({busy_a, busy_b}), 64'b11);
    reset = 1'b1;
    #1;
    chk("abort_busy", 64'({busy_a, busy_b}), 64'd0);
    chk("abort_data", out_data_a, 64'd0);
    @(negedge clk) reset = 1'b0;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done_a || done_b) seen = 1;
    end
    chk("abort_no_done", 64'(seen), 64'd0);

    for (int i = 0; i < 300; i++) begin
      o  = ops[$urandom_range(0, 30)];
      ty = ($urandom_range(0, 9) == 0) ? 2'($urandom) : src_of(o);
      d  = (ty[1]) ? rnd_float(ty == F64) : {$urandom, $urandom};
      run_op(o, d, ty, ($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
